// File: rtl/dram_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : dram_port_if
//  Purpose  : Requester, response and DRAM-side signals of dram_port_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface dram_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    logic                  p0_req;
    logic                  p0_we;
    logic [1:0]            p0_size;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [WORD_WIDTH-1:0] p0_wdata;
    logic                  p0_done;

    logic                  p1_req;
    logic                  p1_we;
    logic [1:0]            p1_size;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [WORD_WIDTH-1:0] p1_wdata;
    logic                  p1_done;

    logic [WORD_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BYTE_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [BYTE_WIDTH-1:0] mem_rdata;

    // System side: both requesters plus the DRAM read port.
    modport master (
        output p0_req, p0_we, p0_size, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_size, p1_addr, p1_wdata,
        input  p0_done, p1_done, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );

    // Controller side.
    modport slave (
        input  p0_req, p0_we, p0_size, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_size, p1_addr, p1_wdata,
        output p0_done, p1_done, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dram_port_ctrl
//  Purpose  : Round-robin two-port controller sequencing little-endian byte,
//             half and word accesses as single-byte DRAM cycles.
//  Revision : 1.0  initial release
// ============================================================================
module dram_port_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    dram_port_if.slave  bus
);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            r_cnt;
    logic                  r_prio;
    logic                  r_gnt;
    logic                  r_we;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic [WORD_WIDTH-1:0] r_rdata;
    logic [WORD_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic                  w_gnt_p1;
    logic                  w_sel_we;
    logic [1:0]            w_sel_size;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [WORD_WIDTH-1:0] w_sel_wdata;
    logic                  w_bad;
    logic [1:0]            w_last;
    logic [WORD_WIDTH-1:0] w_rdata_next;
    logic                  w_access;

    // Port 1 wins when it is the only requester or when it holds priority.
    assign w_gnt_p1    = bus.p1_req & (~bus.p0_req | r_prio);
    assign w_sel_we    = w_gnt_p1 ? bus.p1_we    : bus.p0_we;
    assign w_sel_size  = w_gnt_p1 ? bus.p1_size  : bus.p0_size;
    assign w_sel_addr  = w_gnt_p1 ? bus.p1_addr  : bus.p0_addr;
    assign w_sel_wdata = w_gnt_p1 ? bus.p1_wdata : bus.p0_wdata;

    always_comb begin
        w_bad = 1'b0;
        case (w_sel_size)
            2'd0:    w_bad = 1'b0;
            2'd1:    w_bad = w_sel_addr[0];
            2'd2:    w_bad = |w_sel_addr[1:0];
            default: w_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_last = 2'd0;
        case (r_size)
            2'd1:    w_last = 2'd1;
            2'd2:    w_last = 2'd3;
            default: w_last = 2'd0;
        endcase
    end

    always_comb begin
        w_rdata_next = r_rdata;
        w_rdata_next[int'(r_cnt)*BYTE_WIDTH +: BYTE_WIDTH] = bus.mem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= 2'd0;
            r_prio      <= 1'b0;
            r_gnt       <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.p0_req | bus.p1_req) begin
                        r_gnt   <= w_gnt_p1;
                        r_prio  <= ~w_gnt_p1;
                        r_we    <= w_sel_we;
                        r_size  <= w_sel_size;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_cnt   <= 2'd0;
                        r_rdata <= '0;
                        if (w_bad) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= c_RESP;
                        end else begin
                            r_state <= c_ACCESS;
                        end
                    end
                end
                c_ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= w_rdata_next;
                    end
                    // The final byte is merged straight into the response.
                    if (r_cnt == w_last) begin
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_we ? '0 : w_rdata_next;
                        r_state     <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign w_access      = (r_state == c_ACCESS);
    assign bus.mem_we    = w_access & r_we;
    assign bus.mem_addr  = w_access ? (r_addr + ADDR_WIDTH'(r_cnt)) : '0;
    assign bus.mem_wdata = w_access ? r_wdata[int'(r_cnt)*BYTE_WIDTH +: BYTE_WIDTH] : '0;
    assign bus.p0_done   = (r_state == c_RESP) & ~r_gnt;
    assign bus.p1_done   = (r_state == c_RESP) &  r_gnt;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dram_port_ctrl
//  Purpose  : Directed self-checking bench for dram_port_ctrl with a byte DRAM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dram_port_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dram_port_if bus ();

    dram_port_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Byte DRAM: combinational read, write on the falling edge; 1 KiB aliased.
    logic [7:0] dram [0:1023] = '{default: 8'h00};
    assign bus.mem_rdata = dram[bus.mem_addr[9:0]];
    always @(negedge clk) begin
        if (bus.mem_we) dram[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_port(input int port, input logic req, input logic we,
                              input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata);
        if (port == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_size = size;
            bus.p0_addr = addr; bus.p0_wdata = wdata;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_size = size;
            bus.p1_addr = addr; bus.p1_wdata = wdata;
        end
    endtask

    // Runs one access from IDLE; edges = -1 when done never arrives.
    task automatic do_acc(input int port, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er,
                          output int edges, output logic act);
        logic got;
        got   = 1'b0;
        act   = 1'b0;
        edges = 0;
        drive_port(port, 1'b1, we, size, addr, wdata);
        while (!got && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if ((port == 0) ? bus.p0_done : bus.p1_done) got = 1'b1;
            else act = act | bus.mem_we | (|bus.mem_addr);
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        drive_port(port, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        if (!got) edges = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_port(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        drive_port(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.p0_done, bus.p1_done, bus.mem_we, bus.rsp_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.p0_done, bus.p1_done, bus.mem_we, bus.rsp_err});
        end
        checks++;
        if ({bus.rsp_rdata, bus.mem_addr, bus.mem_wdata} !== 72'h0) begin
            failures++;
            $display("FAIL reset_buses: rdata=%h addr=%h wdata=%h want 0",
                     bus.rsp_rdata, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        logic [31:0] wa [4];
        logic [7:0]  wd [4];
        logic [31:0] exp_a [4] = '{32'h100, 32'h101, 32'h102, 32'h103};
        logic [7:0]  exp_d [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int   nwr;
        int   edges;
        logic got;
        nwr = 0; edges = 0; got = 1'b0;
        drive_port(1, 1'b1, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
        while (!got && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (bus.p1_done) got = 1'b1;
            if (bus.mem_we) begin
                if (nwr < 4) begin wa[nwr] = bus.mem_addr; wd[nwr] = bus.mem_wdata; end
                nwr++;
            end
        end
        checks++;
        if (!got || edges != 5) begin
            failures++;
            $display("FAIL sw_latency: got edges=%0d done=%0b want 5", edges, got);
        end
        checks++;
        if (bus.rsp_err !== 1'b0 || bus.p0_done !== 1'b0) begin
            failures++;
            $display("FAIL sw_err: err=%b p0_done=%b want 0 0", bus.rsp_err, bus.p0_done);
        end
        checks++;
        if (nwr != 4) begin
            failures++;
            $display("FAIL sw_cycles: got %0d writes want 4", nwr);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) begin
                    failures++;
                    $display("FAIL sw_byte%0d: got %h@%h want %h@%h",
                             i, wd[i], wa[i], exp_d[i], exp_a[i]);
                end
            end
        end
        drive_port(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        logic [31:0] rd; logic er; int edges; logic act;
        logic [1:0]  sz   [3] = '{2'd2, 2'd1, 2'd0};
        logic [31:0] ad   [3] = '{32'h100, 32'h102, 32'h101};
        logic [31:0] expd [3] = '{32'hDEADBEEF, 32'h0000DEAD, 32'h000000BE};
        int          expe [3] = '{5, 3, 2};
        for (int i = 0; i < 3; i++) begin
            do_acc(0, 1'b0, sz[i], ad[i], 32'h0, rd, er, edges, act);
            checks++;
            if (rd !== expd[i] || er !== 1'b0 || edges != expe[i]) begin
                failures++;
                $display("FAIL load%0d: got %h err=%b edges=%0d want %h err=0 edges=%0d",
                         i, rd, er, edges, expd[i], expe[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int   seq [3];
        int   n;
        int   cyc;
        logic overlap;
        test_reset();
        n = 0; cyc = 0; overlap = 1'b0;
        drive_port(0, 1'b1, 1'b0, 2'd0, 32'h100, 32'h0);
        drive_port(1, 1'b1, 1'b0, 2'd0, 32'h101, 32'h0);
        while (n < 3 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.p0_done && bus.p1_done) overlap = 1'b1;
            if (bus.p0_done) begin seq[n] = 0; n++; end
            else if (bus.p1_done) begin seq[n] = 1; n++; end
        end
        drive_port(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        drive_port(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
        checks++;
        if (n != 3 || seq[0] != 0 || seq[1] != 1 || seq[2] != 0) begin
            failures++;
            $display("FAIL rr_order: got n=%0d %0d,%0d,%0d want 3 0,1,0",
                     n, seq[0], seq[1], seq[2]);
        end
        checks++;
        if (overlap !== 1'b0) begin
            failures++;
            $display("FAIL rr_overlap: got %b want 0", overlap);
        end
    endtask

    task automatic test_error();
        logic [31:0] rd; logic er; int edges; logic act;
        logic [1:0]  sz [3] = '{2'd2, 2'd3, 2'd1};
        logic [31:0] ad [3] = '{32'h102, 32'h100, 32'h101};
        for (int i = 0; i < 3; i++) begin
            do_acc(1, 1'b1, sz[i], ad[i], 32'h12345678, rd, er, edges, act);
            checks++;
            if (er !== 1'b1 || edges != 1 || act !== 1'b0) begin
                failures++;
                $display("FAIL err%0d: got err=%b edges=%0d bus_act=%b want 1 1 0",
                         i, er, edges, act);
            end
        end
        checks++;
        if (dram[10'h100] !== 8'hEF || dram[10'h103] !== 8'hDE) begin
            failures++;
            $display("FAIL err_nowrite: got %h %h want ef de", dram[10'h100], dram[10'h103]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int edges; logic act;
        drive_port(1, 1'b1, 1'b1, 2'd2, 32'h200, 32'h11223344);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.mem_we, bus.p1_done, bus.p0_done} !== 3'b000 ||
            bus.mem_addr !== 32'h0 || bus.mem_wdata !== 8'h00) begin
            failures++;
            $display("FAIL abort_outputs: we=%b done=%b%b addr=%h wdata=%h want zero",
                     bus.mem_we, bus.p1_done, bus.p0_done, bus.mem_addr, bus.mem_wdata);
        end
        drive_port(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dram[10'h203], dram[10'h202], dram[10'h201], dram[10'h200]} !== 32'h00003344) begin
            failures++;
            $display("FAIL abort_dram: got %h%h%h%h want 00003344",
                     dram[10'h203], dram[10'h202], dram[10'h201], dram[10'h200]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        do_acc(0, 1'b0, 2'd2, 32'h200, 32'h0, rd, er, edges, act);
        checks++;
        if (rd !== 32'h00003344 || er !== 1'b0 || edges != 5) begin
            failures++;
            $display("FAIL abort_next: got %h err=%b edges=%0d want 00003344 0 5", rd, er, edges);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int edges; logic act;
        do_acc(1, 1'b1, 2'd0, 32'h303, 32'hFFFFFFA5, rd, er, edges, act);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || edges != 2) begin
            failures++;
            $display("FAIL sb: got rdata=%h err=%b edges=%0d want 0 0 2", rd, er, edges);
        end
        do_acc(1, 1'b0, 2'd2, 32'h300, 32'h0, rd, er, edges, act);
        checks++;
        if (rd !== 32'hA5000000 || er !== 1'b0) begin
            failures++;
            $display("FAIL sb_readback: got %h err=%b want a5000000 0", rd, er);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_rdata !== 32'hA5000000) begin
            failures++;
            $display("FAIL rsp_hold: got %h want a5000000", bus.rsp_rdata);
        end
        do_acc(0, 1'b1, 2'd2, 32'hFFFFFFFC, 32'hCAFEF00D, rd, er, edges, act);
        do_acc(1, 1'b0, 2'd2, 32'hFFFFFFFC, 32'h0, rd, er, edges, act);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0 || edges != 5) begin
            failures++;
            $display("FAIL top_word: got %h err=%b edges=%0d want cafef00d 0 5", rd, er, edges);
        end
        do_acc(0, 1'b0, 2'd1, 32'hFFFFFFFE, 32'h0, rd, er, edges, act);
        checks++;
        if (rd !== 32'h0000CAFE || er !== 1'b0 || edges != 3) begin
            failures++;
            $display("FAIL top_half: got %h err=%b edges=%0d want 0000cafe 0 3", rd, er, edges);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_store();
        test_load();
        test_round_robin();
        test_error();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
